// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module      : instr_fetch_queue
// Description : In-order instruction prefetch queue in front of a busy-handshaked
//               instruction memory, with redirect flush and in-flight drop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8002_0000),
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_busy_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]    C_CAP       = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_ALIGN_MSK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] word_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0]  alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

  logic [CNT_W:0]    w_in_use;
  logic              w_accept;
  logic              w_drop;
  logic              w_fill;
  logic              w_pop;

  // Dropped responses still occupy memory-side slots, so they count against the cap.
  assign w_in_use   = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign mem_req_o  = rst_ni & enable_i & ~redirect_i & (w_in_use < C_CAP);
  assign mem_addr_o = fetch_pc_q;
  assign w_accept   = mem_req_o & ~mem_busy_i;

  assign w_drop = mem_rvalid_i & (drop_cnt_q != '0);
  assign w_fill = mem_rvalid_i & (drop_cnt_q == '0) & (pend_cnt_q != '0);

  assign instr_valid_o = filled_q[head_ptr_q];
  assign instr_o       = word_q[head_ptr_q];
  assign instr_pc_o    = pc_q[head_ptr_q];
  assign w_pop         = instr_valid_o & instr_ready_i;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    word_d      = word_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    pend_cnt_d  = pend_cnt_q;

    if (redirect_i) begin
      // Every outstanding request of the old stream becomes a response to discard.
      fetch_pc_d  = redirect_pc_i & C_ALIGN_MSK;
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      drop_cnt_d  = drop_cnt_q + pend_cnt_q - CNT_W'(w_drop | w_fill);
    end else begin
      if (w_drop) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (w_fill) begin
        word_d[fill_ptr_q]   = mem_rdata_i;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PTR_W'(1);
      end
      if (w_accept) begin
        pc_d[alloc_ptr_q]     = fetch_pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      alloc_cnt_d = alloc_cnt_q + CNT_W'(w_accept) - CNT_W'(w_pop);
      pend_cnt_d  = pend_cnt_q + CNT_W'(w_accept) - CNT_W'(w_fill);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q  <= RESET_PC;
      pc_q        <= '{default: '0};
      word_q      <= '{default: '0};
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
      pend_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      word_q      <= word_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed and random bench for instr_fetch_queue against a
//               queue-based reference model and a fixed-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_busy = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_busy_i    (mem_busy),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; bit filled; } ent_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  ent_t        mq[$];
  rsp_t        memq[$];
  logic [31:0] m_fpc = RST_PC;
  int          m_drop = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] key = '0;
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  // One clock cycle: drive memory response, check DUT, advance memory and model.
  task automatic cycle();
    bit m_req, m_valid, pop, acc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    m_req   = enable && !redirect && (mq.size() + m_drop < DEPTH);
    m_valid = mq.size() > 0 && mq[0].filled;
    @(negedge clk);
    s_req = mem_req; s_addr = mem_addr; s_valid = instr_valid; s_pc = instr_pc; s_instr = instr;
    chk("mem_req", 32'(s_req), 32'(m_req));
    chk("mem_addr", s_addr, m_fpc);
    chk("instr_valid", 32'(s_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr", s_instr, mq[0].word);
      chk("instr_pc", s_pc, mq[0].pc);
    end
    if (mem_req && !mem_busy) begin
      memq.push_back('{due: cyc + lat, data: mem_addr ^ key});
      acc_cnt++;
    end
    pop = m_valid && instr_ready;
    acc = m_req && !mem_busy;
    if (redirect) begin
      m_drop = m_drop + m_unfilled() - (mem_rvalid ? 1 : 0);
      mq.delete();
      m_fpc = redirect_pc & ~32'h3;
    end else begin
      if (mem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{pc: m_fpc, word: m_fpc ^ key, filled: 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    enable = 1'b0; instr_ready = 1'b1; redirect = 1'b0; mem_busy = 1'b0;
    repeat (12) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset values, with enable already high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;

    // Streaming with 1-cycle memory returning word = address
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (c < 2) chk("t1_not_yet_valid", 32'(s_valid), 32'd0);
      else begin
        chk("t1_valid", 32'(s_valid), 32'd1);
        chk("t1_pc", s_pc, RST_PC + 32'(4 * (c - 2)));
        chk("t1_instr_eq_pc", s_instr, RST_PC + 32'(4 * (c - 2)));
      end
    end

    // Fill to the cap with decode stalled, then release one slot
    drain();
    key = 32'hA5C3_0F0F;
    enable = 1'b1; instr_ready = 1'b0; acc_cnt = 0;
    repeat (10) cycle();
    chk("t2_accepts_to_full", 32'(acc_cnt), 32'd4);
    chk("t2_req_low_full", 32'(s_req), 32'd0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0; acc_cnt = 0;
    cycle();
    chk("t2_req_after_pop", 32'(s_req), 32'd1);
    repeat (4) cycle();
    chk("t2_one_refill", 32'(acc_cnt), 32'd1);

    // Busy stall holds the address and yields a single entry
    drain();
    enable = 1'b1; mem_busy = 1'b1; instr_ready = 1'b0; acc_cnt = 0;
    cycle();
    begin
      logic [31:0] hold;
      hold = s_addr;
      chk("t3_req_busy", 32'(s_req), 32'd1);
      cycle(); chk("t3_addr_hold1", s_addr, hold);
      cycle(); chk("t3_addr_hold2", s_addr, hold);
      mem_busy = 1'b0;
      cycle();
      enable = 1'b0;
      repeat (4) cycle();
      chk("t3_single_accept", 32'(acc_cnt), 32'd1);
      chk("t3_head_pc", s_pc, hold);
      instr_ready = 1'b1;
      cycle(); cycle();
      chk("t3_no_duplicate", 32'(s_valid), 32'd0);
    end

    // Redirect with two requests in flight on a 3-cycle memory
    drain();
    lat = 3; enable = 1'b1; instr_ready = 1'b1;
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    cycle();
    chk("t4_no_req_on_redirect", 32'(s_req), 32'd0);
    redirect = 1'b0;
    cycle();
    chk("t4_new_addr", s_addr, 32'h0000_1000);
    chk("t4_new_req", 32'(s_req), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    chk("t4_found_valid", 32'(found), 32'd1);
    chk("t4_first_pc", s_pc, 32'h0000_1000);

    // Redirect coincident with a response and a pop
    drain();
    lat = 2; enable = 1'b1; instr_ready = 1'b0;
    cycle(); cycle(); cycle();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_2000;
    cycle();
    chk("t5_pop_on_redirect", 32'(s_valid), 32'd1);
    redirect = 1'b0;
    cycle(); chk("t5_empty_a", 32'(s_valid), 32'd0);
    cycle(); chk("t5_empty_b", 32'(s_valid), 32'd0);
    cycle(); chk("t5_empty_c", 32'(s_valid), 32'd0);
    cycle();
    chk("t5_new_valid", 32'(s_valid), 32'd1);
    chk("t5_new_pc", s_pc, 32'h0000_2000);
    chk("t5_new_instr", s_instr, 32'h0000_2000 ^ key);

    // Address wrap, then asynchronous reset mid-stream
    drain();
    lat = 1; enable = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    cycle();
    redirect = 1'b0;
    cycle(); chk("t6_addr_fff8", s_addr, 32'hFFFF_FFF8);
    cycle(); chk("t6_addr_fffc", s_addr, 32'hFFFF_FFFC);
    cycle(); chk("t6_addr_wrap", s_addr, 32'h0000_0000);
    cycle(); cycle();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", instr, 32'd0);
    chk("t6_rst_instr_pc", instr_pc, 32'd0);
    chk("t6_rst_mem_addr", mem_addr, RST_PC);
    memq.delete(); mq.delete(); m_drop = 0; m_fpc = RST_PC;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic
    for (int seg = 0; seg < 6; seg++) begin
      lat = $urandom_range(1, 4);
      repeat (100) begin
        enable      = ($urandom_range(0, 9) < 8);
        mem_busy    = ($urandom_range(0, 3) == 0);
        instr_ready = ($urandom_range(0, 9) < 7);
        redirect    = ($urandom_range(0, 24) == 0);
        redirect_pc = $urandom;
        cycle();
      end
    end
    redirect = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
